// File: rtl/mist1032isa_arbiter_response_router_pkg.sv
// Shared arbiter definitions: requester port tags and the response-slot state encoding.
package mist1032isa_arbiter_pkg;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mist1032isa_arbiter_response_router_if.sv
// Response-side bus bundle: shared response channel, matching-queue read port, two requester ports.
interface mist1032isa_arbiter_response_router_if #(
  parameter int unsigned DW = 32
);
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_busy;
  logic          q_rd_req;
  logic          q_rd_valid;
  logic          q_rd_flag;
  logic          q_rd_empty;
  logic          port0_valid;
  logic [DW-1:0] port0_data;
  logic          port0_busy;
  logic          port1_valid;
  logic [DW-1:0] port1_data;
  logic          port1_busy;

  modport master (
    input  resp_valid, resp_data, q_rd_valid, q_rd_flag, q_rd_empty, port0_busy, port1_busy,
    output resp_busy, q_rd_req, port0_valid, port0_data, port1_valid, port1_data
  );

  modport slave (
    output resp_valid, resp_data, q_rd_valid, q_rd_flag, q_rd_empty, port0_busy, port1_busy,
    input  resp_busy, q_rd_req, port0_valid, port0_data, port1_valid, port1_data
  );
endinterface

// File: rtl/mist1032isa_arbiter_response_router_slot.sv
// Single-entry response slot: holds payload and destination tag until the destination port takes it.
module mist1032isa_arbiter_response_slot
  import mist1032isa_arbiter_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          load_dest,
  input  logic [DW-1:0] load_data,
  input  logic          busy0,
  input  logic          busy1,
  output logic          full,
  output logic          dest,
  output logic [DW-1:0] data,
  output logic          deliver
);

  arb_state_e    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          dest_q, dest_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    deliver = (state_q == ST_HOLD) && !((dest_q == ARB_PORT1) ? busy1 : busy0);
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (load) begin
          state_d = ST_HOLD;
          data_d  = load_data;
          dest_d  = load_dest;
        end
        ST_HOLD: if (deliver) begin
          // Reload on the delivering cycle keeps back-to-back responses bubble-free.
          if (load) begin
            data_d = load_data;
            dest_d = load_dest;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dest_q  <= ARB_PORT0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  assign full = (state_q == ST_HOLD);
  assign dest = dest_q;
  assign data = data_q;

endmodule

// File: rtl/mist1032isa_arbiter_response_router.sv
// Routes the shared response stream to the requester tagged in the matching queue.
// Optional debug counters enabled by defining MIST1032ISA_ARBITER_RESP_COUNTER_EN.
module mist1032isa_arbiter_response_router
  import mist1032isa_arbiter_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic iCLOCK,
  input  logic iRESET,
  input  logic iFLASH,
  mist1032isa_arbiter_response_router_if.master bus,
`ifdef MIST1032ISA_ARBITER_RESP_COUNTER_EN
  output logic [CW-1:0] oDBG_CNT0,
  output logic [CW-1:0] oDBG_CNT1,
  output logic [CW-1:0] oDBG_ORPHAN_CNT,
`endif
  output logic oERR_ORPHAN
);

  logic          hold;
  logic          dest;
  logic          deliver;
  logic [DW-1:0] slot_data;
  logic          resp_busy;
  logic          accept;
  logic          match;
  logic          orphan_q, orphan_d;

  mist1032isa_arbiter_response_slot #(.DW(DW)) u_slot (
    .clk       (iCLOCK),
    .rst       (iRESET),
    .flush     (iFLASH),
    .load      (match),
    .load_dest (bus.q_rd_flag),
    .load_data (bus.resp_data),
    .busy0     (bus.port0_busy),
    .busy1     (bus.port1_busy),
    .full      (hold),
    .dest      (dest),
    .data      (slot_data),
    .deliver   (deliver)
  );

  always_comb begin
    resp_busy = hold && !deliver && !iFLASH;
    // Reset gating keeps the pop request low while reset is held.
    accept    = bus.resp_valid && !resp_busy && !iFLASH && !iRESET;
    match     = accept && bus.q_rd_valid && !bus.q_rd_empty;
    orphan_d  = accept && !match;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) orphan_q <= 1'b0;
    else        orphan_q <= orphan_d;
  end

  assign bus.resp_busy   = resp_busy;
  assign bus.q_rd_req    = match;
  assign bus.port0_valid = hold && (dest == ARB_PORT0) && !iFLASH;
  assign bus.port1_valid = hold && (dest == ARB_PORT1) && !iFLASH;
  assign bus.port0_data  = bus.port0_valid ? slot_data : '0;
  assign bus.port1_data  = bus.port1_valid ? slot_data : '0;
  assign oERR_ORPHAN     = orphan_q;

`ifdef MIST1032ISA_ARBITER_RESP_COUNTER_EN
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, ocnt_q, ocnt_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    ocnt_d = ocnt_q;
    if (bus.port0_valid && !bus.port0_busy) cnt0_d = cnt0_q + CW'(1);
    if (bus.port1_valid && !bus.port1_busy) cnt1_d = cnt1_q + CW'(1);
    if (orphan_d && (ocnt_q != '1))         ocnt_d = ocnt_q + CW'(1);
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      ocnt_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign oDBG_CNT0       = cnt0_q;
  assign oDBG_CNT1       = cnt1_q;
  assign oDBG_ORPHAN_CNT = ocnt_q;
`endif

endmodule
